zap_multiply_long: RTL
======================

ZAP_MULTIPLY_LONG -- requirements
Module: zap_multiply_long

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width; a multiple of PART_W.
REQ-002 SHALL have parameter PART_W, default 16, width of each partial-product multiplier operand.
REQ-003 SHALL have ports, listed as name, direction, width, meaning:
- i_clk  in  1  sole clock; all state updates on its rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_clear  in  1  synchronous abort.
- i_start  in  1  request a new operation.
- i_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- i_long  in  1  1 = 2*DATA_W result, 0 = DATA_W result.
- i_acc  in  1  1 = add accumulator.
- i_rm, i_rs  in  DATA_W  multiplicand, multiplier.
- i_rn  in  DATA_W  accumulator low word.
- i_rdhi  in  DATA_W  accumulator high word; used only when i_long=1.
- o_rd_lo, o_rd_hi  out  DATA_W  result words.
- o_busy  out  1  an operation is in flight.
- o_done  out  1  one-cycle result-valid pulse.
- o_flag_n, o_flag_z  out  1  negative and zero flags of the result.

Function
REQ-004 SHALL compute rm*rs (+acc if i_acc). Result width 2*DATA_W when i_long=1. When i_long=0, only the low DATA_W bits are kept, o_rd_hi=0, and the accumulator is {0,i_rn}.
REQ-005 SHALL accept i_start only in IDLE with i_clear=0. i_start SHALL be ignored while o_busy=1.
REQ-006 SHALL latch all operands and mode bits on the acceptance edge. Inputs may change afterwards without effect.
REQ-007 SHALL implement FSM IDLE -> LOAD -> PP -> FIX -> DONE -> IDLE.
REQ-008 LOAD SHALL form operand magnitudes when signed and record the product sign as sign(rm) xor sign(rs).
REQ-009 PP SHALL run NPP=(DATA_W/PART_W)^2 cycles. Each cycle adds one PART_W x PART_W unsigned partial product, shifted by PART_W*(i+j), into a 2*DATA_W accumulator. A counter sequences j (rs segment) outer and i (rm segment) inner.
REQ-010 FIX SHALL negate the product when the recorded sign is 1, then add the accumulator, modulo 2^(2*DATA_W).
REQ-011 DONE SHALL assert o_done for exactly one cycle and register the result and flags.
REQ-012 Latency SHALL be NPP+3 cycles from the acceptance edge to o_done high; this is 7 at default parameters.
REQ-013 o_busy SHALL be 1 in LOAD, PP and FIX, and 0 in IDLE and DONE. A new start is accepted in the cycle after DONE.
REQ-014 Outputs o_rd_lo, o_rd_hi and the flags SHALL hold their last result until the next DONE.
REQ-015 o_flag_n SHALL be the MSB of the kept result, and o_flag_z SHALL be 1 when all kept result bits are 0.
REQ-016 i_clear SHALL return the FSM to IDLE at the next edge from any state. It suppresses o_done and leaves the result outputs unchanged. i_clear together with i_start SHALL give clear priority.
REQ-017 Signed case: -2^(DATA_W-1) * -2^(DATA_W-1) SHALL yield the exact 2^(2*DATA_W-2).

Reset
REQ-018 Asserting i_reset_n low SHALL immediately force IDLE and set o_rd_lo=0, o_rd_hi=0, o_busy=0, o_done=0, o_flag_n=0, o_flag_z=0, with the counter and accumulator at 0.
REQ-019 Reset mid-operation SHALL discard the operation with no o_done pulse.

Configuration
REQ-020 With macro ZAP_MULT_EARLY_TERM_EN defined, PP SHALL skip every partial product whose rs-magnitude segment is zero. Latency is then 3 plus the count of nonzero-segment products, with a minimum of 3.
REQ-021 Without ZAP_MULT_EARLY_TERM_EN, latency SHALL be fixed at NPP+3 regardless of data.

Structure
REQ-022 Package zap_mult_pkg SHALL hold the FSM state encoding and the PART_W default constant.
REQ-023 The partial product SHALL be computed in sub-module zap_mult_part (PART_W x PART_W unsigned, combinational), instantiated once and time-multiplexed.

Verification
REQ-024 The bench SHALL cover these directed scenarios (default parameters, macro off unless stated):
- Unsigned long: rm=0xFFFFFFFF, rs=0xFFFFFFFF, i_long=1, i_acc=0 -> {hi,lo}=0xFFFFFFFE_00000001, o_done 7 cycles after acceptance, n=1, z=0.
- Signed long accumulate: rm=-3, rs=7, acc {0,5}, i_signed=1 -> 0xFFFFFFFF_FFFFFFF0, n=1.
- Short MLA: rm=0x10000, rs=0x10000, rn=1, i_long=0 -> lo=0x00000001, hi=0, z=0.
- Zero result: rm=0, rs=0x1234, i_acc=0 -> lo=0, hi=0, z=1. With ZAP_MULT_EARLY_TERM_EN and rs=0x0000_0003, o_done arrives 5 cycles after acceptance.
- i_clear asserted in PP cycle 2 -> IDLE next cycle, no o_done, previous result held. i_start during busy -> ignored.
- i_reset_n low mid-FIX -> all outputs 0 immediately. A new start after release completes normally.

Source files
------------

// File: rtl/zap_mult_pkg.sv
// rtl/zap_mult_pkg.sv - shared FSM encoding and width defaults for the long multiplier
package zap_mult_pkg;

  localparam int PART_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PP   = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } zap_mult_state_e;

endpackage

// File: rtl/zap_mult_part.sv
// rtl/zap_mult_part.sv - combinational PART_W x PART_W unsigned partial-product multiplier
module zap_mult_part
  import zap_mult_pkg::*;
#(
  parameter int PART_W = PART_W_DEF
) (
  input  logic [PART_W-1:0]   i_a,
  input  logic [PART_W-1:0]   i_b,
  output logic [2*PART_W-1:0] o_p
);

  assign o_p = {{PART_W{1'b0}}, i_a} * {{PART_W{1'b0}}, i_b};

endmodule

// File: rtl/zap_multiply_long.sv
// rtl/zap_multiply_long.sv - multi-cycle signed/unsigned (long) multiply-accumulate
// Optional ZAP_MULT_EARLY_TERM_EN skips partial products whose rs segment is zero.
module zap_multiply_long
  import zap_mult_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PART_W = PART_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_clear,
  input  logic              i_start,
  input  logic              i_signed,
  input  logic              i_long,
  input  logic              i_acc,
  input  logic [DATA_W-1:0] i_rm,
  input  logic [DATA_W-1:0] i_rs,
  input  logic [DATA_W-1:0] i_rn,
  input  logic [DATA_W-1:0] i_rdhi,
  output logic [DATA_W-1:0] o_rd_lo,
  output logic [DATA_W-1:0] o_rd_hi,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_flag_n,
  output logic              o_flag_z
);

  localparam int NSEG = DATA_W / PART_W;
  localparam int JW   = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int RW   = 2 * DATA_W;

  zap_mult_state_e r_state;
  zap_mult_state_e w_state_nxt;

  logic [DATA_W-1:0] r_rm;
  logic [DATA_W-1:0] r_rs;
  logic [RW-1:0]     r_addend;
  logic [RW-1:0]     r_prod;
  logic              r_signed;
  logic              r_long;
  logic              r_neg;
  logic [JW-1:0]     r_i;
  logic [JW-1:0]     r_j;
  logic [DATA_W-1:0] r_rd_lo;
  logic [DATA_W-1:0] r_rd_hi;
  logic              r_flag_n;
  logic              r_flag_z;

  logic              w_accept;
  logic [DATA_W-1:0] w_mag_m;
  logic [DATA_W-1:0] w_mag_s;
  logic              w_last_i;
  logic [JW:0]       w_search_from;
  logic              w_next_found;
  logic [JW-1:0]     w_next_j;
  logic [PART_W-1:0] w_seg_a;
  logic [PART_W-1:0] w_seg_b;
  logic [2*PART_W-1:0] w_pp;
  logic [RW-1:0]     w_pp_sh;
  logic [RW-1:0]     w_signed_prod;
  logic [RW-1:0]     w_sum;
  logic [RW-1:0]     w_kept;
  logic              w_flag_n;
  logic              w_flag_z;

  assign w_accept = (r_state == ST_IDLE) && i_start && !i_clear;

  // In LOAD r_rm/r_rs still hold the raw operands; they become magnitudes on the way out.
  assign w_mag_m = (r_signed && r_rm[DATA_W-1]) ? -r_rm : r_rm;
  assign w_mag_s = (r_signed && r_rs[DATA_W-1]) ? -r_rs : r_rs;

  assign w_last_i      = (int'(r_i) == NSEG - 1);
  assign w_search_from = (r_state == ST_LOAD) ? '0 : ((JW+1)'(r_j) + (JW+1)'(1));

`ifdef ZAP_MULT_EARLY_TERM_EN
  logic [DATA_W-1:0] w_seg_src;
  assign w_seg_src = (r_state == ST_LOAD) ? w_mag_s : r_rs;

  always_comb begin
    w_next_found = 1'b0;
    w_next_j     = '0;
    for (int k = NSEG - 1; k >= 0; k--) begin
      if (k >= int'(w_search_from) && w_seg_src[k*PART_W +: PART_W] != '0) begin
        w_next_found = 1'b1;
        w_next_j     = k[JW-1:0];
      end
    end
  end
`else
  assign w_next_found = (int'(w_search_from) < NSEG);
  assign w_next_j     = w_search_from[JW-1:0];
`endif

  assign w_seg_a = r_rm[r_i*PART_W +: PART_W];
  assign w_seg_b = r_rs[r_j*PART_W +: PART_W];

  zap_mult_part #(
    .PART_W (PART_W)
  ) u_part (
    .i_a (w_seg_a),
    .i_b (w_seg_b),
    .o_p (w_pp)
  );

  assign w_pp_sh = RW'(w_pp) << (PART_W * (int'(r_i) + int'(r_j)));

  assign w_signed_prod = r_neg ? -r_prod : r_prod;
  assign w_sum         = w_signed_prod + r_addend;
  assign w_kept        = r_long ? w_sum : {{DATA_W{1'b0}}, w_sum[DATA_W-1:0]};
  assign w_flag_n      = r_long ? w_sum[RW-1] : w_sum[DATA_W-1];
  assign w_flag_z      = (w_kept == '0);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (i_start) w_state_nxt = ST_LOAD;
        ST_LOAD: w_state_nxt = w_next_found ? ST_PP : ST_FIX;
        ST_PP:   if (w_last_i && !w_next_found) w_state_nxt = ST_FIX;
        ST_FIX:  w_state_nxt = ST_DONE;
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rm     <= '0;
      r_rs     <= '0;
      r_addend <= '0;
      r_prod   <= '0;
      r_signed <= 1'b0;
      r_long   <= 1'b0;
      r_neg    <= 1'b0;
      r_i      <= '0;
      r_j      <= '0;
      r_rd_lo  <= '0;
      r_rd_hi  <= '0;
      r_flag_n <= 1'b0;
      r_flag_z <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rm     <= i_rm;
        r_rs     <= i_rs;
        r_signed <= i_signed;
        r_long   <= i_long;
        if (!i_acc) begin
          r_addend <= '0;
        end else if (i_long) begin
          r_addend <= {i_rdhi, i_rn};
        end else begin
          r_addend <= {{DATA_W{1'b0}}, i_rn};
        end
      end
      if (!i_clear) begin
        case (r_state)
          ST_LOAD: begin
            r_rm   <= w_mag_m;
            r_rs   <= w_mag_s;
            r_neg  <= r_signed && (r_rm[DATA_W-1] ^ r_rs[DATA_W-1]);
            r_prod <= '0;
            r_i    <= '0;
            r_j    <= w_next_j;
          end
          ST_PP: begin
            r_prod <= r_prod + w_pp_sh;
            if (w_last_i) begin
              r_i <= '0;
              if (w_next_found) r_j <= w_next_j;
            end else begin
              r_i <= r_i + JW'(1);
            end
          end
          ST_FIX: begin
            r_rd_lo  <= w_kept[DATA_W-1:0];
            r_rd_hi  <= w_kept[RW-1:DATA_W];
            r_flag_n <= w_flag_n;
            r_flag_z <= w_flag_z;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_busy   = (r_state == ST_LOAD) || (r_state == ST_PP) || (r_state == ST_FIX);
  assign o_done   = (r_state == ST_DONE);
  assign o_rd_lo  = r_rd_lo;
  assign o_rd_hi  = r_rd_hi;
  assign o_flag_n = r_flag_n;
  assign o_flag_z = r_flag_z;

endmodule
